instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Assembles MIPS instruction fields (op, rs, rt, rd, sa, fun, imm16, imm26) into 32-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the instruction field decoder: a test/boot loader stage that fills IMEM before the single-cycle core runs. Input uses a valid/ready handshake. Output is a registered one-word-per-cycle memory write port with an auto-incrementing byte address.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written
MAX_WORDS, 256, capacity in words; the load stops when this many words are written
CNT_W, 9, width of the word counter; MAX_WORDS must be < 2**CNT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins or restarts a load
in_valid  in  1  the field beat is valid
in_ready  out  1  encoder accepts the beat this cycle
fmt  in  2  00 R-type, 01 I-type, 10 J-type, 11 illegal
op  in  6  opcode
rs  in  5  source register
rt  in  5  target register
rd  in  5  destination register
sa  in  5  shift amount
fun  in  6  function code
imm16  in  16  I-type immediate
imm26  in  26  J-type target
last  in  1  the beat is the final instruction of the program
mem_we  out  1  instruction memory write strobe
mem_addr  out  32  byte address of the write
mem_wdata  out  32  encoded instruction word
count  out  CNT_W  number of words written or in flight in this load
busy  out  1  in the LOAD state
done  out  1  in the DONE state
err  out  1  sticky error: illegal fmt, or overflow without last

Behaviour:
- Reset (async, rst_n=0) sets: state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, in_ready=0, busy=0, done=0, err=0.
- State IDLE: in_ready=0. On start, go to LOAD, clear count to 0, clear err.
- State LOAD: in_ready = (count < MAX_WORDS) && !start. This term is combinational.
- Acceptance occurs when in_valid && in_ready are both high.
- Encoding on acceptance:
  - R: {op,rs,rt,rd,sa,fun}
  - I: {op,rs,rt,imm16}
  - J: {op,imm26}
  - Unused fields are ignored.
- Latency is 1 cycle. An accepted legal beat in cycle N produces, in cycle N+1, mem_we=1, mem_wdata=the encoded word, and mem_addr=BASE_ADDR+4*count_at_N. count increments at the N edge.
- mem_we is a one-cycle pulse per word. mem_addr and mem_wdata hold their values when mem_we=0.
- Back-to-back acceptance gives one write per cycle.
- fmt=11 beat: it is accepted (consumed), no write is issued, count is unchanged, err is set.
- An illegal beat with last=1 still ends the load and goes to DONE.
- Leaving LOAD for DONE happens on the acceptance edge when either:
  - the beat has last=1, or
  - count reaches MAX_WORDS; if last=0 on that beat, err is also set (overflow).
- The final mem_we pulse occurs in the first DONE cycle; done is high in that same cycle.
- State DONE: in_ready=0, done=1. start goes to LOAD, clears count and err, and clears done on the next cycle.
- start while in LOAD restarts the load: in_ready=0 that cycle (no beat accepted), count goes to 0, err is cleared. A write already pending from the previous cycle still completes, at its original address.
- start in IDLE or DONE is as above. start during reset has no effect.
- Reset mid-load aborts immediately; any pending write is dropped (mem_we=0).
- Outputs: busy = (state==LOAD); done = (state==DONE). All memory outputs are registered.

Test Plan:
- Reset, start, one R beat (op=0, rs=1, rt=2, rd=3, sa=0, fun=0x20, last=1) -> next cycle mem_we=1, mem_addr=0x0, mem_wdata=0x00221820, done=1, count=1.
- I beat (op=0x08, rs=1, rt=2, imm16=0x0005) followed by J beat (op=0x02, imm26=0x0000100, last=1), back-to-back -> writes 0x20220005 at 0x0 and 0x08000100 at 0x4 on consecutive cycles, err=0.
- MAX_WORDS=4: stream 5 valid beats with last=0 -> 4 writes at 0x0, 0x4, 0x8, 0xC; in_ready=0 after the 4th acceptance; DONE with err=1; 5th beat never accepted.
- fmt=11 between two R beats -> only 2 mem_we pulses at 0x0 and 0x4; err=1 sticky until the next start.
- start asserted while in_valid=1 in LOAD after 3 words -> no acceptance that cycle; count=0; the next accepted beat writes at BASE_ADDR; err cleared.
- rst_n pulled low the cycle after an acceptance -> mem_we stays 0; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and streams them into IMEM
// through a registered write port with an auto-incrementing byte address.
//
// state | meaning
// IDLE  | waiting for start; no beats accepted
// LOAD  | accepting field beats, one memory write per legal beat
// DONE  | program finished (last beat or capacity reached); waiting for start
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fmt,
    input  logic [5:0]       op,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [4:0]       sa,
    input  logic [5:0]       fun,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic             last,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             accept;
    logic             legal;
    logic             reach_max;
    logic [CNT_W-1:0] count_inc;
    logic [31:0]      word;

    always_comb begin
        word = 32'h0;
        case (fmt)
            2'b00:   word = {op, rs, rt, rd, sa, fun};
            2'b01:   word = {op, rs, rt, imm16};
            2'b10:   word = {op, imm26};
            default: word = 32'h0;
        endcase
    end

    assign legal     = (fmt != 2'b11);
    assign count_inc = count_q + CNT_W'(1);
    assign reach_max = legal && (count_inc == MAX_CNT);
    assign in_ready  = (state_q == LOAD) && (count_q < MAX_CNT) && !start;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (accept) begin
                    if (legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {{(30-CNT_W){1'b0}}, count_q, 2'b00};
                        mem_wdata_d = word;
                        count_d     = count_inc;
                    end else begin
                        err_d = 1'b1;
                    end
                    // Overflow: capacity filled but the program did not say it was finished.
                    if (reach_max && !last) err_d = 1'b1;
                    if (last || reach_max) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);

endmodule
